// File: rtl/ahb_apb_pkg.sv
// rtl/ahb_apb_pkg.sv - shared AHB encodings, error-response states and region defaults
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [1:0] HRESP_OKAY  = 2'd0;
  localparam logic [1:0] HRESP_ERROR = 2'd1;

  typedef enum logic [1:0] {
    ERR_IDLE = 2'd0,
    ERR_1    = 2'd1,
    ERR_2    = 2'd2
  } err_state_t;

  localparam int          DEF_ADDR_W      = 32;
  localparam int          DEF_DATA_W      = 32;
  localparam int          DEF_NUM_SLV     = 3;
  localparam logic [31:0] DEF_BASE_ADDR   = 32'h8000_0000;
  localparam int          DEF_REGION_LOG2 = 26;

endpackage

// File: rtl/ahb_slave_if_if.sv
// rtl/ahb_slave_if_if.sv - AHB-Lite master/slave signal bundle seen by the bridge front end
interface ahb_slave_if_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              hwrite;
  logic              hreadyin;
  logic [1:0]        htrans;
  logic [2:0]        hsize;
  logic [ADDR_W-1:0] haddr;
  logic [DATA_W-1:0] hwdata;
  logic              hreadyout;
  logic [1:0]        hresp;
  logic [DATA_W-1:0] hrdata;

  modport master (
    output hwrite, hreadyin, htrans, hsize, haddr, hwdata,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hwrite, hreadyin, htrans, hsize, haddr, hwdata,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_addr_decode.sv
// rtl/ahb_addr_decode.sv - combinational address to {mapped, one-hot region select}
module ahb_addr_decode #(
  parameter int                ADDR_W      = 32,
  parameter int                NUM_SLV     = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                REGION_LOG2 = 26
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic               mapped,
  output logic [NUM_SLV-1:0] sel
);

  // One extra bit so a window ending at the top of the address space cannot wrap.
  localparam logic [ADDR_W:0] BASE_X = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] TOP_X  = BASE_X + ((ADDR_W+1)'(NUM_SLV) << REGION_LOG2);

  logic [ADDR_W:0] addr_x;
  logic [ADDR_W:0] region;

  always_comb begin
    addr_x = {1'b0, addr};
    mapped = (addr_x >= BASE_X) && (addr_x < TOP_X);
    region = (addr_x - BASE_X) >> REGION_LOG2;
    sel    = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      sel[i] = mapped && (region == (ADDR_W+1)'(i));
    end
  end

endmodule

// File: rtl/ahb_slave_if.sv
// rtl/ahb_slave_if.sv - AHB-Lite slave front end of the AHB-to-APB bridge (option: AHB_SLV_BURST_CHK_EN)
module ahb_slave_if
  import ahb_apb_pkg::*;
#(
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter int                DATA_W      = DEF_DATA_W,
  parameter int                NUM_SLV     = DEF_NUM_SLV,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int                REGION_LOG2 = DEF_REGION_LOG2
) (
  input  logic               hclk,
  input  logic               hreset,
  ahb_slave_if_if.slave      ahb,
  input  logic               bridge_ready,
  input  logic [DATA_W-1:0]  prdata,
  output logic               valid,
  output logic [ADDR_W-1:0]  haddr1,
  output logic [ADDR_W-1:0]  haddr2,
  output logic [DATA_W-1:0]  hwdata1,
  output logic [DATA_W-1:0]  hwdata2,
  output logic               hwrite_reg,
  output logic               hwrite_reg2,
  output logic [NUM_SLV-1:0] tempselx
);

  err_state_t         err_state, err_next;
  logic               mapped;
  logic [NUM_SLV-1:0] sel;
  logic               trans_req;
  logic               burst_bad;

  ahb_addr_decode #(
    .ADDR_W     (ADDR_W),
    .NUM_SLV    (NUM_SLV),
    .BASE_ADDR  (BASE_ADDR),
    .REGION_LOG2(REGION_LOG2)
  ) u_decode (
    .addr  (ahb.haddr),
    .mapped(mapped),
    .sel   (sel)
  );

  assign trans_req = ahb.hreadyin & ahb.htrans[1];

`ifdef AHB_SLV_BURST_CHK_EN
  // A SEQ beat must continue from the last accepted address by exactly one transfer size.
  assign burst_bad = (ahb.htrans == HTRANS_SEQ) &&
                     ((ahb.hsize > 3'd2) || (ahb.haddr != haddr1 + (ADDR_W'(1) << ahb.hsize)));
`else
  logic unused_hsize;
  assign unused_hsize = ^ahb.hsize;
  assign burst_bad    = 1'b0;
`endif

  assign valid      = trans_req & mapped & ~burst_bad & (err_state == ERR_IDLE) & ~hreset;
  assign ahb.hrdata = prdata;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      err_state <= ERR_IDLE;
    end else begin
      err_state <= err_next;
    end
  end

  always_comb begin
    err_next      = err_state;
    ahb.hreadyout = 1'b1;
    ahb.hresp     = HRESP_OKAY;
    case (err_state)
      ERR_IDLE: begin
        ahb.hreadyout = bridge_ready;
        if (trans_req && (!mapped || burst_bad)) begin
          err_next = ERR_1;
        end
      end
      ERR_1: begin
        ahb.hreadyout = 1'b0;
        ahb.hresp     = HRESP_ERROR;
        err_next      = ERR_2;
      end
      ERR_2: begin
        ahb.hresp = HRESP_ERROR;
        err_next  = ERR_IDLE;
      end
      default: err_next = ERR_IDLE;
    endcase
    if (hreset) begin
      ahb.hreadyout = 1'b1;
    end
  end

  // Everything advances only on AHB ready so wait states freeze the pipeline.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      haddr1      <= '0;
      haddr2      <= '0;
      hwdata1     <= '0;
      hwdata2     <= '0;
      hwrite_reg  <= 1'b0;
      hwrite_reg2 <= 1'b0;
      tempselx    <= '0;
    end else if (ahb.hreadyin) begin
      haddr1      <= ahb.haddr;
      haddr2      <= haddr1;
      hwdata1     <= ahb.hwdata;
      hwdata2     <= hwdata1;
      hwrite_reg  <= ahb.hwrite;
      hwrite_reg2 <= hwrite_reg;
      tempselx    <= valid ? sel : '0;
    end
  end

endmodule
